// File: rtl/data_mem_responder.sv
// data_mem_responder: byte-addressable data memory with RISC-V style load/store sizing and access rejection.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset (clears outputs, never the memory)
//   wr, rd     store / load requests sampled at the rising edge
//   addr       9-bit byte address; addr[8:2] word index, addr[1:0] byte lane
//   funct3     access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   wr_data    right-aligned store data
//   rd_data    right-aligned, extended load result (held between reads)
//   rd_valid   rd_data updated by a load accepted at the previous edge
//   err        one-cycle pulse after a rejected access
//   err_count  saturating count of rejected accesses
// Optional feature: define DMEM_MISALIGN_ERR_EN to reject misaligned halfword/word
// accesses; by default they are force-aligned and proceed.
module data_mem_responder #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic              rd,
  input  logic [8:0]        addr,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              err,
  output logic [7:0]        err_count
);
  localparam int IW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic              live;
  logic [IW-1:0]     idx;
  logic [1:0]        off;
  logic              is_h, is_w, ld_ok, st_ok, mis, reject, do_wr, do_rd;
  logic [3:0]        be;
  logic [DATA_W-1:0] lanes, word, sh, ld_val;
  always_comb begin
    is_h   = funct3[1:0] == 2'b01;
    is_w   = funct3[1:0] == 2'b10;
    ld_ok  = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    st_ok  = funct3 inside {3'b000, 3'b001, 3'b010};
`ifdef DMEM_MISALIGN_ERR_EN
    mis    = (is_h & addr[0]) | (is_w & |addr[1:0]);
`else
    mis    = 1'b0;
`endif
    // Force-alignment: halfwords drop addr[0], words drop addr[1:0]
    off    = is_w ? 2'b00 : is_h ? {addr[1], 1'b0} : addr[1:0];
    idx    = addr[IW+1:2];
    // A simultaneous wr+rd is one rejected event even though the write still lands
    reject = live & ((wr & rd) | (wr & (!st_ok | mis)) | (rd & (!ld_ok | mis)));
    do_wr  = live & wr & st_ok & !mis;
    do_rd  = live & rd & !wr & ld_ok & !mis;
    be     = is_w ? 4'b1111 : is_h ? 4'b0011 << off : 4'b0001 << off;
    lanes  = is_w ? wr_data : is_h ? {2{wr_data[15:0]}} : {4{wr_data[7:0]}};
    word   = mem[idx];
    sh     = word >> {off, 3'b000};
    ld_val = is_w ? word
           : is_h ? {{16{sh[15] & !funct3[2]}}, sh[15:0]}
           : {{24{sh[7] & !funct3[2]}}, sh[7:0]};
  end
  always_ff @(posedge clk)
    if (do_wr)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= lanes[8*i +: 8];
  // live stays low through the first edge after reset release, so that edge's access is ignored
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      live      <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      live     <= 1'b1;
      rd_valid <= do_rd;
      err      <= reject;
      if (do_rd) rd_data <= ld_val;
      if (reject && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench for data_mem_responder (directed vectors).
module tb_data_mem_responder;
  logic        clk = 1'b0, reset = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [8:0]  addr = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        rd_valid, err;
  logic [7:0]  err_count;
  int          checks = 0, errors = 0, exp_cnt = 0;
  typedef struct {bit v; bit e; logic [31:0] d;} resp_t;
  resp_t q[$];
  string nq[$];

  always #5 clk = ~clk;

  data_mem_responder dut (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd), .addr(addr), .funct3(funct3),
    .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid), .err(err), .err_count(err_count)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic op(input bit w, input bit r, input logic [8:0] a, input logic [2:0] f, input logic [31:0] d);
    wr = w; rd = r; addr = a; funct3 = f; wr_data = d;
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic st(input logic [8:0] a, input logic [2:0] f, input logic [31:0] d);
    op(1'b1, 1'b0, a, f, d);
  endtask

  task automatic ld(input string n, input logic [8:0] a, input logic [2:0] f, input logic [31:0] e);
    q.push_back('{1'b1, 1'b0, e});
    nq.push_back(n);
    op(1'b0, 1'b1, a, f, 32'h0);
  endtask

  task automatic rej(input string n, input bit w, input bit r, input logic [8:0] a, input logic [2:0] f, input logic [31:0] d);
    q.push_back('{1'b0, 1'b1, 32'h0});
    nq.push_back(n);
    exp_cnt = exp_cnt < 255 ? exp_cnt + 1 : 255;
    op(w, r, a, f, d);
  endtask

  // Monitor: every presented response must match the next queued expectation
  always @(negedge clk)
    if (rd_valid || err) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected output: rd_valid=%0b err=%0b rd_data=%h", rd_valid, err, rd_data);
      end else begin
        resp_t e;
        string n;
        e = q.pop_front();
        n = nq.pop_front();
        if (rd_valid !== e.v || err !== e.e || (e.v && rd_data !== e.d)) begin
          errors++;
          $display("FAIL %s: got rd_valid=%0b err=%0b rd_data=%h expected rd_valid=%0b err=%0b rd_data=%h",
                   n, rd_valid, err, rd_data, e.v, e.e, e.d);
        end
      end
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    #2;
    check("reset rd_data", rd_data, 32'h0);
    check("reset rd_valid", {31'h0, rd_valid}, 32'h0);
    check("reset err", {31'h0, err}, 32'h0);
    check("reset err_count", {24'h0, err_count}, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    // Basic store/load and extension
    st(9'h010, 3'b010, 32'h8000_00F1);
    ld("LW 0x010", 9'h010, 3'b010, 32'h8000_00F1);
    ld("LB 0x010", 9'h010, 3'b000, 32'hFFFF_FFF1);
    ld("LBU 0x010", 9'h010, 3'b100, 32'h0000_00F1);
    ld("LH 0x012", 9'h012, 3'b001, 32'hFFFF_8000);
    ld("LHU 0x012", 9'h012, 3'b101, 32'h0000_8000);
    st(9'h040, 3'b010, 32'h5A5A_1234);
    // Simultaneous write and read
    rej("wr+rd 0x020", 1'b1, 1'b1, 9'h020, 3'b010, 32'hCAFE_BABE);
    ld("LW 0x020 after wr+rd", 9'h020, 3'b010, 32'hCAFE_BABE);
    check("err_count after wr+rd", {24'h0, err_count}, 32'h1);
    // Misaligned accesses
`ifdef DMEM_MISALIGN_ERR_EN
    rej("LW 0x013 misaligned", 1'b0, 1'b1, 9'h013, 3'b010, 32'h0);
    rej("LH 0x013 misaligned", 1'b0, 1'b1, 9'h013, 3'b001, 32'h0);
    rej("LHU 0x011 misaligned", 1'b0, 1'b1, 9'h011, 3'b101, 32'h0);
    rej("SW 0x016 misaligned", 1'b1, 1'b0, 9'h016, 3'b010, 32'h0102_0304);
`else
    ld("LW 0x013 aligned", 9'h013, 3'b010, 32'h8000_00F1);
    ld("LH 0x013 aligned", 9'h013, 3'b001, 32'hFFFF_8000);
    ld("LHU 0x011 aligned", 9'h011, 3'b101, 32'h0000_00F1);
    st(9'h016, 3'b010, 32'h0102_0304);
    ld("LW 0x014 after SW 0x016", 9'h014, 3'b010, 32'h0102_0304);
`endif
    // Illegal funct3 encodings
    rej("load funct3 011", 1'b0, 1'b1, 9'h010, 3'b011, 32'h0);
    rej("store funct3 100", 1'b1, 1'b0, 9'h010, 3'b100, 32'h0);
    rej("store funct3 111", 1'b1, 1'b0, 9'h010, 3'b111, 32'h0);
    ld("LW 0x010 unchanged", 9'h010, 3'b010, 32'h8000_00F1);
    check("err_count before reset", {24'h0, err_count}, exp_cnt);
    // Reset with a read in flight; the write at the release edge must be ignored
    wr = 1'b0; rd = 1'b1; addr = 9'h010; funct3 = 3'b010;
    @(posedge clk);
    #2 reset = 1'b0; rd = 1'b0;
    #1;
    check("mid-read reset rd_valid", {31'h0, rd_valid}, 32'h0);
    check("mid-read reset rd_data", rd_data, 32'h0);
    check("mid-read reset err", {31'h0, err}, 32'h0);
    check("mid-read reset err_count", {24'h0, err_count}, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1; wr = 1'b1; addr = 9'h040; funct3 = 3'b010; wr_data = 32'hFFFF_FFFF;
    @(posedge clk); #1 wr = 1'b0;
    exp_cnt = 0;
    ld("LW 0x040 release-edge write ignored", 9'h040, 3'b010, 32'h5A5A_1234);
    ld("LW 0x010 kept over reset", 9'h010, 3'b010, 32'h8000_00F1);
    check("err_count after reset", {24'h0, err_count}, 32'h0);
    // Byte/halfword stores
    st(9'h010, 3'b010, 32'h1122_3344);
    st(9'h011, 3'b000, 32'h0000_00AB);
    ld("LW 0x010 after SB", 9'h010, 3'b010, 32'h1122_AB44);
    @(negedge clk);
    @(negedge clk);
    check("idle rd_valid", {31'h0, rd_valid}, 32'h0);
    check("idle rd_data hold", rd_data, 32'h1122_AB44);
    st(9'h012, 3'b001, 32'h1234_BEEF);
    ld("LW 0x010 after SH", 9'h010, 3'b010, 32'hBEEF_AB44);
    ld("LHU 0x012", 9'h012, 3'b101, 32'h0000_BEEF);
    ld("LB 0x011", 9'h011, 3'b000, 32'hFFFF_FFAB);
    st(9'h1FC, 3'b010, 32'hDEAD_BEEF);
    ld("LW 0x1FC top word", 9'h1FC, 3'b010, 32'hDEAD_BEEF);
    // Saturation of err_count
    for (int i = 0; i < 260; i++) rej("saturation reject", 1'b0, 1'b1, 9'h000, 3'b110, 32'h0);
    check("err_count saturated", {24'h0, err_count}, exp_cnt);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing responses: %0d outstanding expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
